regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file (RegWrite / WriteRegister / WriteData, posedge Clk) between two writeback requesters, A and B.
- After reset, a sequencer zero-fills registers 1..NUM_REGS-1. The block then switches to round-robin arbitration of writes.
- Sits between the writeback stages and the regfile. Read ports are not touched.

---
 rtl/regfile_write_arbiter_if.sv | 29 ++
 rtl/regfile_write_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-side bundle between the two writeback requesters, the arbiter and the register file.
// master = requester/regfile side, slave = arbiter.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  ReqA;
  logic [ADDR_WIDTH-1:0] WrRegA;
  logic [DATA_WIDTH-1:0] WrDataA;
  logic                  AckA;
  logic                  ReqB;
  logic [ADDR_WIDTH-1:0] WrRegB;
  logic [DATA_WIDTH-1:0] WrDataB;
  logic                  AckB;
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  InitDone;

  modport master (
    output ReqA, WrRegA, WrDataA, ReqB, WrRegB, WrDataB,
    input  AckA, AckB, RegWrite, WriteRegister, WriteData, InitDone
  );

  modport slave (
    input  ReqA, WrRegA, WrDataA, ReqB, WrRegB, WrDataB,
    output AckA, AckB, RegWrite, WriteRegister, WriteData, InitDone
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between requesters A and B, zero-filling registers after reset.
// Define REGARB_FIXED_PRIO_EN to make A always win contention instead of round-robin.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input logic                    Clk,
  input logic                    Reset,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StInit, StArb} state_e;

  // A single-register file has nothing to zero-fill beyond r0.
  localparam bit DoInit = (INIT_ON_RESET != 0) && (NUM_REGS > 1);
  localparam logic [ADDR_WIDTH-1:0] LastReg = ADDR_WIDTH'(NUM_REGS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic arb_en;
  logic grant_a;
  logic grant_b;

  assign arb_en = (state_q == StArb) && init_done_q && !Reset;

`ifdef REGARB_FIXED_PRIO_EN
  assign grant_a = arb_en && bus.ReqA;
  assign grant_b = arb_en && bus.ReqB && !bus.ReqA;
`else
  logic last_b_q, last_b_d;

  assign grant_a = arb_en && bus.ReqA && (!bus.ReqB || last_b_q);
  assign grant_b = arb_en && bus.ReqB && !(bus.ReqA && last_b_q);

  // Dropped r0 writes leave the fairness pointer alone.
  always_comb begin
    last_b_d = last_b_q;
    if (grant_a && (bus.WrRegA != '0)) begin
      last_b_d = 1'b0;
    end else if (grant_b && (bus.WrRegB != '0)) begin
      last_b_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    reg_write_d = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    unique case (state_q)
      StInit: begin
        reg_write_d = 1'b1;
        wr_reg_d    = cnt_q;
        wr_data_d   = '0;
        cnt_d       = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LastReg) begin
          state_d = StArb;
        end
      end
      StArb: begin
        // First ARB edge follows the last init write; acks open only after it.
        init_done_d = 1'b1;
        if (grant_a && (bus.WrRegA != '0)) begin
          reg_write_d = 1'b1;
          wr_reg_d    = bus.WrRegA;
          wr_data_d   = bus.WrDataA;
        end else if (grant_b && (bus.WrRegB != '0)) begin
          reg_write_d = 1'b1;
          wr_reg_d    = bus.WrRegB;
          wr_data_d   = bus.WrDataB;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= DoInit ? StInit : StArb;
      cnt_q       <= ADDR_WIDTH'(1);
      init_done_q <= !DoInit;
      reg_write_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      reg_write_q <= reg_write_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign bus.AckA          = grant_a;
  assign bus.AckB          = grant_b;
  assign bus.RegWrite      = reg_write_q;
  assign bus.WriteRegister = wr_reg_q;
  assign bus.WriteData     = wr_data_q;
  assign bus.InitDone      = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural regfile behind the write port.
module tb_regfile_write_arbiter;

`ifdef REGARB_FIXED_PRIO_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  logic [31:0] regs [32];

  regfile_write_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  regfile_write_arbiter #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (5),
    .NUM_REGS     (32),
    .INIT_ON_RESET(1)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Regfile model: commits whatever the arbiter presents, r0 included, so stray r0 writes show.
  always @(posedge Clk) begin
    if (bus.RegWrite) regs[bus.WriteRegister] <= bus.WriteData;
  end

  task automatic idle_reqs();
    bus.ReqA = 1'b0; bus.WrRegA = '0; bus.WrDataA = '0;
    bus.ReqB = 1'b0; bus.WrRegB = '0; bus.WrDataB = '0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle_reqs();
    bus.ReqA = 1'b1; bus.WrRegA = 5'd9; bus.WrDataA = 32'd1;
    #12;
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd0 || bus.WriteData !== 32'd0 ||
        bus.InitDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b reg=%0d data=%0d done=%b, want 0 0 0 0",
               bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.InitDone);
    end
    checks++;
    if (bus.AckA !== 1'b0 || bus.AckB !== 1'b0) begin
      errors++;
      $display("FAIL reset_acks: got AckA=%b AckB=%b, want 0 0", bus.AckA, bus.AckB);
    end
    idle_reqs();
    @(posedge Clk); #1;
    Reset = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      @(posedge Clk); #1;
      checks++;
      if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'(k) || bus.WriteData !== 32'd0) begin
        errors++;
        $display("FAIL init_write_%0d: got we=%b reg=%0d data=%0d, want 1 %0d 0",
                 k, bus.RegWrite, bus.WriteRegister, bus.WriteData, k);
      end
    end
    checks++;
    if (bus.InitDone !== 1'b0) begin
      errors++;
      $display("FAIL init_done_early: got %b, want 0", bus.InitDone);
    end
    @(posedge Clk); #1;
    checks++;
    if (bus.InitDone !== 1'b1 || bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL init_done: got done=%b we=%b, want 1 0", bus.InitDone, bus.RegWrite);
    end
  endtask

  // Fresh after reset LastGrant=B, so A wins first; fixed priority makes A win every time.
  task automatic test_round_robin();
    logic exp_a;
    bus.ReqA = 1'b1; bus.WrRegA = 5'd3; bus.WrDataA = 32'd15;
    bus.ReqB = 1'b1; bus.WrRegB = 5'd4; bus.WrDataB = 32'd25;
    for (int i = 0; i < 6; i++) begin
      exp_a = FixedPrio ? 1'b1 : ((i % 2) == 0);
      #1;
      checks++;
      if (bus.AckA !== exp_a || bus.AckB !== !exp_a) begin
        errors++;
        $display("FAIL rr_ack_%0d: got AckA=%b AckB=%b, want %b %b",
                 i, bus.AckA, bus.AckB, exp_a, !exp_a);
      end
      @(posedge Clk); #1;
      checks++;
      if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== (exp_a ? 5'd3 : 5'd4) ||
          bus.WriteData !== (exp_a ? 32'd15 : 32'd25)) begin
        errors++;
        $display("FAIL rr_write_%0d: got we=%b reg=%0d data=%0d, want 1 %0d %0d", i,
                 bus.RegWrite, bus.WriteRegister, bus.WriteData, exp_a ? 3 : 4,
                 exp_a ? 15 : 25);
      end
    end
    idle_reqs();
    @(posedge Clk); #1;
    checks++;
    if (regs[3] !== 32'd15 || bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL rr_commit: got r3=%0d we=%b, want 15 0", regs[3], bus.RegWrite);
    end
    checks++;
    if (!FixedPrio && regs[4] !== 32'd25) begin
      errors++;
      $display("FAIL rr_commit_b: got r4=%0d, want 25", regs[4]);
    end
  endtask

  task automatic test_single_write();
    bus.ReqA = 1'b1; bus.WrRegA = 5'd2; bus.WrDataA = 32'd42;
    #1;
    checks++;
    if (bus.AckA !== 1'b1 || bus.AckB !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: got AckA=%b AckB=%b, want 1 0", bus.AckA, bus.AckB);
    end
    @(posedge Clk); #1;
    idle_reqs();
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd2 || bus.WriteData !== 32'd42) begin
      errors++;
      $display("FAIL single_write: got we=%b reg=%0d data=%0d, want 1 2 42",
               bus.RegWrite, bus.WriteRegister, bus.WriteData);
    end
    @(posedge Clk); #1;
    checks++;
    if (regs[2] !== 32'd42 || bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL single_commit: got r2=%0d we=%b, want 42 0", regs[2], bus.RegWrite);
    end
  endtask

  task automatic test_reg_zero();
    bus.ReqB = 1'b1; bus.WrRegB = 5'd0; bus.WrDataB = 32'd15;
    #1;
    checks++;
    if (bus.AckB !== 1'b1 || bus.AckA !== 1'b0) begin
      errors++;
      $display("FAIL r0_ack: got AckA=%b AckB=%b, want 0 1", bus.AckA, bus.AckB);
    end
    @(posedge Clk); #1;
    idle_reqs();
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd2 || bus.WriteData !== 32'd42) begin
      errors++;
      $display("FAIL r0_drop: got we=%b reg=%0d data=%0d, want 0 2 42",
               bus.RegWrite, bus.WriteRegister, bus.WriteData);
    end
    @(posedge Clk); #1;
    checks++;
    if (regs[0] !== 32'd0) begin
      errors++;
      $display("FAIL r0_read: got %0d, want 0", regs[0]);
    end
  endtask

  // LastGrant is still A (the r0 write did not count), so round-robin starts with B here.
  task automatic test_contention();
    logic exp_a;
    bus.ReqA = 1'b1; bus.WrRegA = 5'd5; bus.WrDataA = 32'd7;
    bus.ReqB = 1'b1; bus.WrRegB = 5'd6; bus.WrDataB = 32'd8;
    for (int i = 0; i < 4; i++) begin
      exp_a = FixedPrio ? 1'b1 : ((i % 2) == 1);
      #1;
      checks++;
      if (bus.AckA !== exp_a || bus.AckB !== !exp_a) begin
        errors++;
        $display("FAIL cont_ack_%0d: got AckA=%b AckB=%b, want %b %b",
                 i, bus.AckA, bus.AckB, exp_a, !exp_a);
      end
      @(posedge Clk); #1;
      checks++;
      if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== (exp_a ? 5'd5 : 5'd6) ||
          bus.WriteData !== (exp_a ? 32'd7 : 32'd8)) begin
        errors++;
        $display("FAIL cont_write_%0d: got we=%b reg=%0d data=%0d, want 1 %0d %0d", i,
                 bus.RegWrite, bus.WriteRegister, bus.WriteData, exp_a ? 5 : 6,
                 exp_a ? 7 : 8);
      end
    end
    idle_reqs();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid_init();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    bus.ReqA = 1'b1; bus.WrRegA = 5'd7; bus.WrDataA = 32'd99;
    for (int k = 1; k <= 9; k++) begin
      @(posedge Clk); #1;
    end
    checks++;
    if (bus.WriteRegister !== 5'd9 || bus.RegWrite !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got reg=%0d we=%b, want 9 1", bus.WriteRegister, bus.RegWrite);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd0 || bus.InitDone !== 1'b0 ||
        bus.AckA !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear: got we=%b reg=%0d done=%b AckA=%b, want 0 0 0 0",
               bus.RegWrite, bus.WriteRegister, bus.InitDone, bus.AckA);
    end
    #1;
    Reset = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      #1;
      checks++;
      if (bus.AckA !== 1'b0) begin
        errors++;
        $display("FAIL mid_holdoff_%0d: got AckA=%b, want 0", k, bus.AckA);
      end
      @(posedge Clk); #1;
      checks++;
      if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'(k)) begin
        errors++;
        $display("FAIL mid_init_%0d: got we=%b reg=%0d, want 1 %0d",
                 k, bus.RegWrite, bus.WriteRegister, k);
      end
    end
    checks++;
    if (bus.AckA !== 1'b0) begin
      errors++;
      $display("FAIL mid_holdoff_end: got AckA=%b, want 0", bus.AckA);
    end
    @(posedge Clk); #1;
    checks++;
    if (bus.InitDone !== 1'b1 || bus.AckA !== 1'b1) begin
      errors++;
      $display("FAIL mid_release: got done=%b AckA=%b, want 1 1", bus.InitDone, bus.AckA);
    end
    @(posedge Clk); #1;
    idle_reqs();
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd7 || bus.WriteData !== 32'd99) begin
      errors++;
      $display("FAIL mid_held_req: got we=%b reg=%0d data=%0d, want 1 7 99",
               bus.RegWrite, bus.WriteRegister, bus.WriteData);
    end
    @(posedge Clk); #1;
    checks++;
    if (regs[7] !== 32'd99 || regs[3] !== 32'd0) begin
      errors++;
      $display("FAIL mid_regs: got r7=%0d r3=%0d, want 99 0", regs[7], regs[3]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_round_robin();
    test_single_write();
    test_reg_zero();
    test_contention();
    test_reset_mid_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
